// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame: GMII receive-side frame parser (rx_clk domain).
//
// Strips the 0x55 preamble and 0xD5 SFD, delays post-SFD bytes by five
// stages so the four FCS bytes can be dropped at end of frame, and delivers
// the payload on a valid/last stream. One cycle of status (done/fcs_ok/
// rx_err/len_err/frame_len) accompanies out_last; runts get a lone done.
//
// Optional feature macro: GMII_RX_FCS_CHECK_EN
//   defined     : CRC-32 residue check drives fcs_ok.
//   not defined : no CRC logic, fcs_ok reads 1 on every done.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_dv, rx_er, rxd   GMII receive inputs
//   out_data/valid/last payload stream (FCS removed)
//   done                one-cycle end-of-frame pulse, qualifies the status below
//   fcs_ok, rx_err, len_err, frame_len  per-frame status
//   good_cnt, bad_cnt   wrapping frame counters
module gmii_rx_frame #(
    parameter int unsigned MAX_LEN = 1518  // payload+FCS limit, must stay below 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        done,
    output logic        fcs_ok,
    output logic        rx_err,
    output logic        len_err,
    output logic [10:0] frame_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    localparam logic [11:0] MaxLenW = 12'(MAX_LEN);

    typedef enum logic [1:0] {StIdle, StPre, StData, StDrop} state_e;

    state_e          state_q, state_d;
    logic [4:0][7:0] line_q, line_d;    // [0] newest, [4] oldest
    logic [11:0]     cnt_q, cnt_d;      // post-SFD bytes, saturating
    logic            err_q, err_d;      // sticky rx_er seen in DATA
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            done_q, done_d;
    logic            fcs_ok_q, fcs_ok_d;
    logic            rx_err_q, rx_err_d;
    logic            len_err_q, len_err_d;
    logic [10:0]     frame_len_q, frame_len_d;
    logic [15:0]     good_cnt_q, good_cnt_d;
    logic [15:0]     bad_cnt_q, bad_cnt_d;
    logic            fcs_good;
    logic            runt;
    logic [11:0]     pay_len;

`ifdef GMII_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d;

    // Reflected CRC-32, one byte per call, LSB first, no final inversion.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    // Running the register over data plus a correct FCS leaves this residue.
    assign fcs_good = (crc_q == 32'hDEBB_20E3);
`else
    assign fcs_good = 1'b1;
`endif

    assign runt    = (cnt_q < 12'd5);
    assign pay_len = cnt_q - 12'd4;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_data_d  = 8'h00;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        done_d      = 1'b0;
        fcs_ok_d    = 1'b0;
        rx_err_d    = 1'b0;
        len_err_d   = 1'b0;
        frame_len_d = 11'd0;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
`ifdef GMII_RX_FCS_CHECK_EN
        crc_d       = crc_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (rx_dv) begin
                    state_d = (rxd == 8'h55) ? StPre : StDrop;
                end
            end
            StPre: begin
                if (!rx_dv) begin
                    state_d = StIdle;
                end else if (rxd == 8'hD5) begin
                    state_d = StData;
                    cnt_d   = 12'd0;
                    err_d   = 1'b0;
`ifdef GMII_RX_FCS_CHECK_EN
                    crc_d   = 32'hFFFF_FFFF;
`endif
                end else if (rxd != 8'h55) begin
                    state_d = StDrop;
                end
            end
            StData: begin
                if (rx_dv) begin
                    line_d = {line_q[3:0], rxd};
                    // Line full: the oldest byte is known not to be FCS.
                    if (!runt) begin
                        out_valid_d = 1'b1;
                        out_data_d  = line_q[4];
                    end
                    if (cnt_q != 12'hFFF) begin
                        cnt_d = cnt_q + 12'd1;
                    end
                    if (rx_er) begin
                        err_d = 1'b1;
                    end
`ifdef GMII_RX_FCS_CHECK_EN
                    crc_d = crc_byte(crc_q, rxd);
`endif
                end else begin
                    // Finalize; a following 0x55 is picked up from IDLE.
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    fcs_ok_d  = fcs_good;
                    rx_err_d  = err_q | runt;
                    len_err_d = (cnt_q > MaxLenW);
                    if (!runt) begin
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                        out_data_d  = line_q[4];
                        frame_len_d = pay_len[11] ? 11'h7FF : pay_len[10:0];
                    end
                    if (fcs_good && !rx_err_d && !len_err_d) begin
                        good_cnt_d = good_cnt_q + 16'd1;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 16'd1;
                    end
                end
            end
            StDrop: begin
                if (!rx_dv) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            line_q      <= '0;
            cnt_q       <= 12'd0;
            err_q       <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            fcs_ok_q    <= 1'b0;
            rx_err_q    <= 1'b0;
            len_err_q   <= 1'b0;
            frame_len_q <= 11'd0;
            good_cnt_q  <= 16'd0;
            bad_cnt_q   <= 16'd0;
`ifdef GMII_RX_FCS_CHECK_EN
            crc_q       <= 32'hFFFF_FFFF;
`endif
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            fcs_ok_q    <= fcs_ok_d;
            rx_err_q    <= rx_err_d;
            len_err_q   <= len_err_d;
            frame_len_q <= frame_len_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
`ifdef GMII_RX_FCS_CHECK_EN
            crc_q       <= crc_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign fcs_ok    = fcs_ok_q;
    assign rx_err    = rx_err_q;
    assign len_err   = len_err_q;
    assign frame_len = frame_len_q;
    assign good_cnt  = good_cnt_q;
    assign bad_cnt   = bad_cnt_q;

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Bench for gmii_rx_frame: directed and random frames, expected beats and
// status pushed into queues by a frame-level model, popped by a monitor.
module tb_gmii_rx_frame;

    localparam int unsigned MaxLen = 64;
`ifdef GMII_RX_FCS_CHECK_EN
    localparam bit FcsEn = 1'b1;
`else
    localparam bit FcsEn = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit          fcs_ok;
        bit          chk_fcs;
        bit          rx_err;
        bit          len_err;
        bit          beats;
        logic [10:0] len;
        logic [15:0] good;
        logic [15:0] bad;
    } st_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [7:0]  out_data;
    logic        out_valid, out_last, done, fcs_ok, rx_err, len_err;
    logic [10:0] frame_len;
    logic [15:0] good_cnt, bad_cnt;

    gmii_rx_frame #(.MAX_LEN(MaxLen)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_dv     (rx_dv),
        .rx_er     (rx_er),
        .rxd       (rxd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .done      (done),
        .fcs_ok    (fcs_ok),
        .rx_err    (rx_err),
        .len_err   (len_err),
        .frame_len (frame_len),
        .good_cnt  (good_cnt),
        .bad_cnt   (bad_cnt)
    );

    always #4 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [8:0]  beat_q[$];     // {last, data}
    st_t         stat_q[$];
    logic [15:0] m_good = 16'd0;
    logic [15:0] m_bad = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output with nothing expected (t=%0t)", name, $time);
    endtask

    // Standard Ethernet FCS value over the first n bytes.
    function automatic logic [31:0] eth_crc(input bq_t d, input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic bq_t with_fcs(input bq_t p);
        bq_t         r;
        logic [31:0] c;
        r = p;
        c = eth_crc(p, p.size());
        for (int k = 0; k < 4; k++) r.push_back(c[8*k +: 8]);
        return r;
    endfunction

    // Frame-level model: post holds every post-SFD byte as sent.
    task automatic expect_frame(input bq_t post, input bit er);
        int          n;
        bit          fm;
        logic [31:0] c;
        st_t         s;
        n  = post.size();
        fm = 1'b0;
        if (n >= 4) begin
            c  = eth_crc(post, n - 4);
            fm = (post[n-4] == c[7:0]) && (post[n-3] == c[15:8]) &&
                 (post[n-2] == c[23:16]) && (post[n-1] == c[31:24]);
        end
        s.beats = (n >= 5);
        if (s.beats) begin
            for (int i = 0; i <= n - 5; i++) beat_q.push_back({(i == n - 5), post[i]});
        end
        s.fcs_ok  = FcsEn ? fm : 1'b1;
        s.chk_fcs = s.beats || !FcsEn;
        s.rx_err  = er || !s.beats;
        s.len_err = (n > MaxLen);
        s.len     = !s.beats ? 11'd0 : ((n - 4 > 2047) ? 11'd2047 : 11'(n - 4));
        if (s.fcs_ok && !s.rx_err && !s.len_err) m_good++;
        else m_bad++;
        s.good = m_good;
        s.bad  = m_bad;
        stat_q.push_back(s);
    endtask

    task automatic drive(input bq_t w, input int er_at, input int ifg);
        foreach (w[i]) begin
            @(posedge clk);
            #1;
            rx_dv = 1'b1;
            rxd   = w[i];
            rx_er = (i == er_at);
        end
        repeat (ifg) begin
            @(posedge clk);
            #1;
            rx_dv = 1'b0;
            rx_er = 1'b0;
            rxd   = 8'($urandom);
        end
    endtask

    task automatic frame(input int npre, input bq_t post, input int er_idx, input int ifg);
        bq_t w;
        for (int i = 0; i < npre; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        foreach (post[i]) w.push_back(post[i]);
        expect_frame(post, er_idx >= 0);
        drive(w, (er_idx >= 0) ? npre + 1 + er_idx : -1, ifg);
    endtask

    function automatic bq_t ramp(input int n);
        bq_t r;
        for (int i = 0; i < n; i++) r.push_back(8'(i));
        return r;
    endfunction

    // Monitor: pops expectations whenever the DUT presents output.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [8:0] e;
            st_t        s;
            if (out_last && !out_valid) fail_event("last_without_valid");
            if (out_valid) begin
                if (beat_q.size() == 0) begin
                    fail_event("unexpected_beat");
                end else begin
                    e = beat_q.pop_front();
                    check("beat_data", out_data, e[7:0]);
                    check("beat_last", out_last, e[8]);
                end
            end
            if (done) begin
                if (stat_q.size() == 0) begin
                    fail_event("unexpected_done");
                end else begin
                    s = stat_q.pop_front();
                    if (s.chk_fcs) check("fcs_ok", fcs_ok, s.fcs_ok);
                    check("rx_err", rx_err, s.rx_err);
                    check("len_err", len_err, s.len_err);
                    check("frame_len", frame_len, s.len);
                    check("good_cnt", good_cnt, s.good);
                    check("bad_cnt", bad_cnt, s.bad);
                    check("last_with_done", out_last, s.beats);
                end
            end else begin
                check("idle_status", {fcs_ok, rx_err, len_err, frame_len}, 0);
            end
        end
    end

    initial begin
        bq_t p;
        bq_t w;
        int  n, er, ifg;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);
        check("rst_status", {fcs_ok, rx_err, len_err, frame_len}, 0);
        check("rst_counters", {good_cnt, bad_cnt}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Clean 60-byte frame, then the same with a corrupt FCS byte.
        p = with_fcs(ramp(60));
        frame(7, p, -1, 3);
        p[63] = p[63] ^ 8'h01;
        frame(7, p, -1, 3);

        // rx_er on payload byte 10.
        frame(7, with_fcs(ramp(60)), 10, 3);

        // Runt: three post-SFD bytes.
        p = '{8'h11, 8'h22, 8'h33};
        frame(1, p, -1, 3);

        // Bad preamble: dropped silently, then a clean frame.
        w = '{8'h55, 8'h55, 8'hAA, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        drive(w, -1, 2);
        frame(7, with_fcs(ramp(46)), -1, 3);

        // Back-to-back with a single idle cycle between frames.
        frame(7, with_fcs(ramp(46)), -1, 1);
        frame(7, with_fcs(ramp(46)), -1, 3);

        // Oversize: 66 payload + 4 FCS = 70 post-SFD bytes.
        frame(7, with_fcs(ramp(66)), -1, 3);

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            p.delete();
            n = $urandom_range(0, 70);
            for (int i = 0; i < n; i++) p.push_back(8'($urandom));
            p = with_fcs(p);
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = $urandom_range(0, p.size() - 1);
                p[k] = p[k] ^ (8'h01 << $urandom_range(0, 7));
            end
            er  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, p.size() - 1)) : -1;
            ifg = $urandom_range(1, 4);
            frame($urandom_range(1, 7), p, er, ifg);
        end
        repeat (8) @(posedge clk);

        // Reset at payload byte 20: bytes 0..13 have been emitted by then.
        p = with_fcs(ramp(40));
        for (int i = 0; i < 14; i++) beat_q.push_back({1'b0, p[i]});
        w.delete();
        for (int i = 0; i < 7; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        for (int i = 0; i < 20; i++) w.push_back(p[i]);
        drive(w, -1, 0);
        @(posedge clk);
        #1;
        rxd   = p[20];
        rst_n = 1'b0;
        m_good = 16'd0;
        m_bad  = 16'd0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_done", done, 0);
        check("midrst_status", {fcs_ok, rx_err, len_err, frame_len}, 0);
        check("midrst_counters", {good_cnt, bad_cnt}, 0);
        @(posedge clk);
        #1;
        rxd = p[21];
        rst_n = 1'b1;
        w.delete();
        for (int i = 22; i < p.size(); i++) w.push_back(p[i]);
        drive(w, -1, 3);
        frame(7, with_fcs(ramp(50)), -1, 3);

        // Drain with a bounded wait.
        for (int i = 0; i < 200 && (beat_q.size() != 0 || stat_q.size() != 0); i++) begin
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        check("queues_drained", beat_q.size() + stat_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
